// File: rtl/clk_step_ctrl.sv
// Turns rising edges of the divided slow clock into one-cycle CPU tick strobes,
// with free-run, halt and counted burst modes. Optional breakpoint input: CLK_STEP_BKPT_EN.
module clk_step_ctrl #(
  parameter int unsigned STEP_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              slow_clk_i,
  input  logic              run_i,
  input  logic              step_i,
  input  logic [STEP_W-1:0] step_count_i,
  output logic              tick_o,
  output logic              halted_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  tick_count_o
`ifdef CLK_STEP_BKPT_EN
  ,
  input  logic              bkpt_i
`endif
);

  localparam int unsigned WARM_CYCLES = SYNC_STAGES + 1;
  localparam int unsigned WARM_W      = $clog2(WARM_CYCLES + 1);

  typedef enum logic [1:0] {HALT, RUN, BURST} state_t;

  state_t              state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                prev_q;
  logic                step_q;
  logic [WARM_W-1:0]   warm_cnt;
  logic [STEP_W-1:0]   remaining;

  logic                synced_c;
  logic                warm_done_c;
  logic                rise_c;
  logic                step_re_c;
  logic                tick_en_c;
  logic [STEP_W-1:0]   burst_len_c;

  assign synced_c    = sync_q[SYNC_STAGES-1];
  assign warm_done_c = (warm_cnt == WARM_W'(WARM_CYCLES));
  // Masked until the synchronizer has flushed, so a high slow clock at release is not an edge
  assign rise_c      = synced_c & ~prev_q & warm_done_c;
  assign step_re_c   = step_i & ~step_q;
  assign burst_len_c = (step_count_i == '0) ? STEP_W'(1) : step_count_i;

`ifdef CLK_STEP_BKPT_EN
  assign tick_en_c = rise_c & ~bkpt_i & (((state == RUN) & run_i) | (state == BURST));
`else
  assign tick_en_c = rise_c & (((state == RUN) & run_i) | (state == BURST));
`endif

  // Slow-clock synchronizer, edge history, step edge and warm-up counter
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      step_q   <= 1'b0;
      warm_cnt <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk_i};
      prev_q <= synced_c;
      step_q <= step_i;
      if (!warm_done_c) begin
        warm_cnt <= warm_cnt + WARM_W'(1);
      end
    end
  end

  // Mode FSM with registered tick, status and tick counter
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state        <= HALT;
      tick_o       <= 1'b0;
      halted_o     <= 1'b1;
      busy_o       <= 1'b0;
      remaining    <= '0;
      tick_count_o <= '0;
    end else begin
      tick_o <= tick_en_c;
      if (tick_en_c) begin
        tick_count_o <= tick_count_o + CNT_W'(1);
      end
`ifdef CLK_STEP_BKPT_EN
      if (bkpt_i) begin
        state     <= HALT;
        halted_o  <= 1'b1;
        busy_o    <= 1'b0;
        remaining <= '0;
      end else
`endif
      begin
        case (state)
          HALT: begin
            if (run_i) begin
              state    <= RUN;
              halted_o <= 1'b0;
            end else if (step_re_c) begin
              state     <= BURST;
              halted_o  <= 1'b0;
              busy_o    <= 1'b1;
              remaining <= burst_len_c;
            end
          end
          RUN: begin
            if (!run_i) begin
              state    <= HALT;
              halted_o <= 1'b1;
            end
          end
          BURST: begin
            if (rise_c) begin
              remaining <= remaining - STEP_W'(1);
              if (remaining <= STEP_W'(1)) begin
                state    <= run_i ? RUN : HALT;
                halted_o <= ~run_i;
                busy_o   <= 1'b0;
              end
            end
          end
          default: begin
            state    <= HALT;
            halted_o <= 1'b1;
            busy_o   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Directed bench for clk_step_ctrl: warm-up, free-run, bursts, priority, reset and
// (when CLK_STEP_BKPT_EN is defined) breakpoint. Tick counter built 3 bits wide to reach wrap.
module tb_clk_step_ctrl;

  localparam int unsigned STEP_W = 8;
  localparam int unsigned CNT_W  = 3;

  logic              clk = 1'b0;
  logic              reset_ni = 1'b0;
  logic              slow_clk = 1'b1;
  logic              run = 1'b0;
  logic              step = 1'b0;
  logic [STEP_W-1:0] step_count = '0;
  logic              tick;
  logic              halted;
  logic              busy;
  logic [CNT_W-1:0]  tick_count;
`ifdef CLK_STEP_BKPT_EN
  logic              bkpt = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int phase = 0;
  bit slow_en = 1'b0;
  int tick_seen = 0;
  logic prev_tick = 1'b0;

  clk_step_ctrl #(.STEP_W(STEP_W), .SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .reset_ni     (reset_ni),
    .slow_clk_i   (slow_clk),
    .run_i        (run),
    .step_i       (step),
    .step_count_i (step_count),
    .tick_o       (tick),
    .halted_o     (halted),
    .busy_o       (busy),
    .tick_count_o (tick_count)
`ifdef CLK_STEP_BKPT_EN
    ,
    .bkpt_i       (bkpt)
`endif
  );

  always #5 clk = ~clk;

  // Slow clock: period 12 cycles, 6 high / 6 low, updated 2 time units after posedge
  always @(posedge clk) begin
    cyc = cyc + 1;
    #2;
    if (slow_en) begin
      phase = (phase + 1) % 12;
      slow_clk = (phase < 6);
      if (phase == 0) rise_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n cycles sampling at negedge; every tick must be 1 wide and 3 cycles after a rise
  task automatic tc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        tick_seen++;
        chk("tick_latency", 32'(cyc - rise_cyc), 32'd3);
        chk("tick_width", 32'(prev_tick), 32'd0);
      end
      prev_tick = tick;
    end
  endtask

  initial begin
    // Reset with slow clock already high
    tc(5);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_halted", 32'(halted), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(tick_count), 32'd0);

    // Release into RUN with slow high: warm-up must hide the stale level
    reset_ni = 1'b1;
    run = 1'b1;
    tick_seen = 0;
    tc(10);
    chk("warm_ticks", 32'(tick_seen), 32'd0);
    chk("warm_halted", 32'(halted), 32'd0);
    chk("warm_count", 32'(tick_count), 32'd0);

    // Free run for 60 cycles: rises at 7,19,31,43,55 -> 5 ticks
    phase = 5;
    slow_en = 1'b1;
    tick_seen = 0;
    tc(60);
    chk("run_ticks", 32'(tick_seen), 32'd5);
    chk("run_count", 32'(tick_count), 32'd5);
    run = 1'b0;
    tc(1);
    chk("run_drop_halted", 32'(halted), 32'd1);

    // Burst of 3
    phase = 5;
    step_count = 8'd3;
    step = 1'b1;
    tick_seen = 0;
    tc(1);
    chk("b3_busy", 32'(busy), 32'd1);
    chk("b3_halted_low", 32'(halted), 32'd0);
    step = 1'b0;
    tc(40);
    chk("b3_ticks", 32'(tick_seen), 32'd3);
    chk("b3_halted", 32'(halted), 32'd1);
    chk("b3_busy_end", 32'(busy), 32'd0);
    chk("b3_count_wrap", 32'(tick_count), 32'd0);

    // Step count 0 behaves as 1
    phase = 5;
    step_count = 8'd0;
    step = 1'b1;
    tick_seen = 0;
    tc(1);
    chk("b0_busy", 32'(busy), 32'd1);
    step = 1'b0;
    tc(40);
    chk("b0_ticks", 32'(tick_seen), 32'd1);
    chk("b0_halted", 32'(halted), 32'd1);
    chk("b0_count", 32'(tick_count), 32'd1);

    // Burst of 4, extra step ignored, run raised mid-burst -> RUN continues
    phase = 5;
    step_count = 8'd4;
    step = 1'b1;
    tick_seen = 0;
    tc(1);
    step = 1'b0;
    tc(13);
    step = 1'b1;
    tc(1);
    step = 1'b0;
    tc(11);
    run = 1'b1;
    tc(14);
    chk("b4_mid_ticks", 32'(tick_seen), 32'd3);
    chk("b4_mid_busy", 32'(busy), 32'd1);
    tc(35);
    chk("b4_total_ticks", 32'(tick_seen), 32'd6);
    chk("b4_busy_end", 32'(busy), 32'd0);
    chk("b4_running", 32'(halted), 32'd0);
    chk("b4_count", 32'(tick_count), 32'd7);
    run = 1'b0;
    tc(1);
    chk("b4_halt", 32'(halted), 32'd1);

    // run and step together in HALT: RUN wins, no burst
    phase = 5;
    step_count = 8'd2;
    run = 1'b1;
    step = 1'b1;
    tc(1);
    chk("pri_halted", 32'(halted), 32'd0);
    chk("pri_busy", 32'(busy), 32'd0);
    step = 1'b0;
    tc(3);
    chk("pri_busy_hold", 32'(busy), 32'd0);
    run = 1'b0;
    tc(1);
    chk("pri_halt", 32'(halted), 32'd1);

`ifdef CLK_STEP_BKPT_EN
    // Breakpoint in RUN on the cycle a tick would issue
    phase = 5;
    run = 1'b1;
    tick_seen = 0;
    tc(9);
    bkpt = 1'b1;
    tc(1);
    chk("bkpt_tick", 32'(tick_seen), 32'd0);
    chk("bkpt_halted", 32'(halted), 32'd1);
    tc(2);
    chk("bkpt_hold", 32'(halted), 32'd1);
    bkpt = 1'b0;
    run = 1'b0;
    tc(3);
`endif

    // Reset after two ticks of a 5-step burst
    phase = 5;
    step_count = 8'd5;
    step = 1'b1;
    tick_seen = 0;
    tc(1);
    step = 1'b0;
    tc(25);
    chk("r5_ticks", 32'(tick_seen), 32'd2);
    chk("r5_busy", 32'(busy), 32'd1);
    reset_ni = 1'b0;
    #1;
    chk("r5_rst_halted", 32'(halted), 32'd1);
    chk("r5_rst_busy", 32'(busy), 32'd0);
    chk("r5_rst_count", 32'(tick_count), 32'd0);
    chk("r5_rst_tick", 32'(tick), 32'd0);
    tick_seen = 0;
    tc(3);
    reset_ni = 1'b1;
    tc(40);
    chk("r5_after_ticks", 32'(tick_seen), 32'd0);
    chk("r5_after_halted", 32'(halted), 32'd1);
    chk("r5_after_count", 32'(tick_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
